// File: rtl/led_frame_sequencer_if.sv
// Pixel stream between the frame sequencer and the WS2812 bit driver.
//   pixel_grb   : scaled GRB pixel, G[23:16] R[15:8] B[7:0]
//   pixel_valid : pixel_grb holds a pixel for the driver
//   pixel_ready : driver can accept a pixel this cycle
//   drv_idle    : driver has finished shifting every bit out
interface led_frame_sequencer_if;
   logic [23:0] pixel_grb;
   logic        pixel_valid;
   logic        pixel_ready;
   logic        drv_idle;

   modport master (
      output pixel_grb,
      output pixel_valid,
      input  pixel_ready,
      input  drv_idle
   );

   modport slave (
      input  pixel_grb,
      input  pixel_valid,
      output pixel_ready,
      output drv_idle
   );
endinterface

// File: rtl/led_frame_sequencer.sv
// Frame-level controller for a WS2812 chain: holds a NUM_LEDS pixel buffer,
// streams brightness-scaled pixels to the bit driver, then enforces the
// latch gap and pulses frame completion.
//   clk_50Mhz, rst   : clock, asynchronous active-high reset
//   wr_en_i/addr/grb : host pixel buffer write port (out-of-range ignored)
//   frame_start_i    : one-cycle frame request
//   auto_refresh_i   : enables the periodic request timer
//   brightness_i     : global brightness, latched at frame start
//   busy_o           : frame in progress
//   frame_done_o     : one-cycle pulse at the end of the latch gap
//   cur_index_o      : pixel being fetched or sent
//   drv              : pixel stream to the bit driver
module led_frame_sequencer #(
   parameter int unsigned NUM_LEDS       = 64,
   parameter int unsigned ADDR_W         = 6,
   parameter int unsigned LATCH_CYCLES   = 2600,
   parameter int unsigned REFRESH_CYCLES = 833333,
   parameter int unsigned REFRESH_W      = 20
) (
   input  logic                  clk_50Mhz,
   input  logic                  rst,
   input  logic                  wr_en_i,
   input  logic [ADDR_W-1:0]     wr_addr_i,
   input  logic [23:0]           wr_grb_i,
   input  logic                  frame_start_i,
   input  logic                  auto_refresh_i,
   input  logic [7:0]            brightness_i,
   output logic                  busy_o,
   output logic                  frame_done_o,
   output logic [ADDR_W-1:0]     cur_index_o,
   led_frame_sequencer_if.master drv
);

   localparam int unsigned LATCH_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
   localparam int unsigned IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_SCALE, S_SEND, S_DRAIN, S_LATCH, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    idx_q, idx_d;
   logic [8:0]           bscale_q, bscale_d;
   logic                 pending_q, pending_d;
   logic [REFRESH_W-1:0] refresh_q, refresh_d;
   logic [LATCH_W-1:0]   latch_q, latch_d;
   logic [23:0]          grb_q, grb_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, done_q;

   logic [23:0]          mem [NUM_LEDS];
   logic [23:0]          rd_q;

   logic                 wr_ok_c, refresh_hit_c, request_c;

   // One channel scaled by bscale in 1..256: keep bits [15:8] of the product.
   function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [8:0] s);
      return 8'((17'(c) * 17'(s)) >> 8);
   endfunction

   assign wr_ok_c       = wr_en_i && (32'(wr_addr_i) < NUM_LEDS);
   assign refresh_hit_c = auto_refresh_i && (refresh_q == REFRESH_W'(REFRESH_CYCLES - 1));
   assign request_c     = frame_start_i || refresh_hit_c;

   // Pixel buffer; a same-cycle write and read of one address returns the old word.
   always_ff @(posedge clk_50Mhz) begin
      if (wr_ok_c) mem[IDX_W'(wr_addr_i)] <= wr_grb_i;
      if (state_q == S_FETCH) rd_q <= mem[IDX_W'(idx_q)];
   end

   // Next-state and datapath.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      bscale_d  = bscale_q;
      pending_d = pending_q;
      latch_d   = latch_q;
      grb_d     = grb_q;
      valid_d   = valid_q;
      refresh_d = '0;

      if (auto_refresh_i) refresh_d = refresh_hit_c ? '0 : refresh_q + REFRESH_W'(1);

      // Requests while a frame runs collapse into one pending frame.
      if ((state_q != S_IDLE) && request_c) pending_d = 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (request_c) begin
               bscale_d = 9'(brightness_i) + 9'd1;
               idx_d    = '0;
               state_d  = S_FETCH;
            end
         end
         S_FETCH: state_d = S_SCALE;
         S_SCALE: begin
            grb_d   = {scale_ch(rd_q[23:16], bscale_q),
                       scale_ch(rd_q[15:8],  bscale_q),
                       scale_ch(rd_q[7:0],   bscale_q)};
            valid_d = 1'b1;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (valid_q && drv.pixel_ready) begin
               valid_d = 1'b0;
               if (idx_q == ADDR_W'(NUM_LEDS - 1)) begin
                  state_d = S_DRAIN;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = S_FETCH;
               end
            end
         end
         S_DRAIN: begin
            if (drv.drv_idle) begin
               latch_d = '0;
               state_d = S_LATCH;
            end
         end
         S_LATCH: begin
            if (latch_q == LATCH_W'(LATCH_CYCLES - 1)) state_d = S_DONE;
            else                                        latch_d = latch_q + LATCH_W'(1);
         end
         S_DONE: begin
            // A request landing in DONE itself also chains straight into the next frame.
            if (pending_q || request_c) begin
               bscale_d  = 9'(brightness_i) + 9'd1;
               idx_d     = '0;
               pending_d = 1'b0;
               state_d   = S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk_50Mhz or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         bscale_q  <= '0;
         pending_q <= 1'b0;
         refresh_q <= '0;
         latch_q   <= '0;
         grb_q     <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         bscale_q  <= bscale_d;
         pending_q <= pending_d;
         refresh_q <= refresh_d;
         latch_q   <= latch_d;
         grb_q     <= grb_d;
         valid_q   <= valid_d;
         busy_q    <= (state_d != S_IDLE);
         done_q    <= (state_d == S_DONE);
      end
   end

   assign drv.pixel_grb   = grb_q;
   assign drv.pixel_valid = valid_q;
   assign busy_o          = busy_q;
   assign frame_done_o    = done_q;
   assign cur_index_o     = idx_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Self-checking bench for led_frame_sequencer: expected pixels are queued
// when a frame is requested and popped on every accepted transfer.
module tb_led_frame_sequencer;

   localparam int unsigned NUM_LEDS       = 8;
   localparam int unsigned ADDR_W         = 4;
   localparam int unsigned LATCH_CYCLES   = 40;
   localparam int unsigned REFRESH_CYCLES = 100;
   localparam int unsigned REFRESH_W      = 7;

   logic              clk_50Mhz = 1'b0;
   logic              rst;
   logic              wr_en_i;
   logic [ADDR_W-1:0] wr_addr_i;
   logic [23:0]       wr_grb_i;
   logic              frame_start_i;
   logic              auto_refresh_i;
   logic [7:0]        brightness_i;
   logic              busy_o;
   logic              frame_done_o;
   logic [ADDR_W-1:0] cur_index_o;

   led_frame_sequencer_if pix_if ();

   led_frame_sequencer #(
      .NUM_LEDS      (NUM_LEDS),
      .ADDR_W        (ADDR_W),
      .LATCH_CYCLES  (LATCH_CYCLES),
      .REFRESH_CYCLES(REFRESH_CYCLES),
      .REFRESH_W     (REFRESH_W)
   ) dut (
      .clk_50Mhz     (clk_50Mhz),
      .rst           (rst),
      .wr_en_i       (wr_en_i),
      .wr_addr_i     (wr_addr_i),
      .wr_grb_i      (wr_grb_i),
      .frame_start_i (frame_start_i),
      .auto_refresh_i(auto_refresh_i),
      .brightness_i  (brightness_i),
      .busy_o        (busy_o),
      .frame_done_o  (frame_done_o),
      .cur_index_o   (cur_index_o),
      .drv           (pix_if.master)
   );

   always #10 clk_50Mhz = ~clk_50Mhz;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [23:0] exp_q [$];
   logic [23:0] shadow [NUM_LEDS];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] scale(input logic [23:0] p, input logic [7:0] b);
      logic [23:0] r;
      for (int c = 0; c < 3; c++)
         r[c*8 +: 8] = 8'((int'(p[c*8 +: 8]) * (int'(b) + 1)) / 256);
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk_50Mhz);
      #1;
   endtask

   task automatic write_px(input logic [ADDR_W-1:0] a, input logic [23:0] d);
      wr_en_i   = 1'b1;
      wr_addr_i = a;
      wr_grb_i  = d;
      tick(1);
      wr_en_i   = 1'b0;
      if (int'(a) < int'(NUM_LEDS)) shadow[int'(a)] = d;
   endtask

   task automatic push_frame(input logic [7:0] b);
      for (int i = 0; i < int'(NUM_LEDS); i++) exp_q.push_back(scale(shadow[i], b));
   endtask

   task automatic pulse_start();
      frame_start_i = 1'b1;
      tick(1);
      frame_start_i = 1'b0;
   endtask

   task automatic start_frame(input logic [7:0] b);
      brightness_i = b;
      push_frame(b);
      pulse_start();
   endtask

   // Returns at the cycle frame_done_o is high; cyc = edges waited.
   task automatic wait_done(input string tag, input int max, output int cyc);
      cyc = 0;
      while (frame_done_o !== 1'b1 && cyc < max) begin
         tick(1);
         cyc++;
      end
      if (frame_done_o !== 1'b1) check({tag, "_timeout"}, 32'(frame_done_o), 1);
   endtask

   // Transfer monitor, sampled on the falling edge.
   bit prev_xfer = 1'b0;
   always @(negedge clk_50Mhz) begin
      if (rst) begin
         prev_xfer = 1'b0;
      end else begin
         if (prev_xfer) check("valid_drop", 32'(pix_if.pixel_valid), 0);
         prev_xfer = pix_if.pixel_valid && pix_if.pixel_ready;
         if (prev_xfer) begin
            check("idx_range", 32'(int'(cur_index_o) < int'(NUM_LEDS)), 1);
            if (exp_q.size() == 0) check("extra_pixel", 32'(exp_q.size()), 1);
            else                   check("pixel", 32'(pix_if.pixel_grb), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation did not finish (got timeout expected finish)");
      $fatal(1);
   end

   initial begin
      int          cyc;
      int          n;
      logic [23:0] held;

      rst                = 1'b1;
      wr_en_i            = 1'b0;
      wr_addr_i          = '0;
      wr_grb_i           = '0;
      frame_start_i      = 1'b0;
      auto_refresh_i     = 1'b0;
      brightness_i       = 8'd255;
      pix_if.pixel_ready = 1'b1;
      pix_if.drv_idle    = 1'b1;

      // Reset state
      #25;
      check("rst_busy",  32'(busy_o), 0);
      check("rst_done",  32'(frame_done_o), 0);
      check("rst_idx",   32'(cur_index_o), 0);
      check("rst_valid", 32'(pix_if.pixel_valid), 0);
      check("rst_grb",   32'(pix_if.pixel_grb), 0);
      @(negedge clk_50Mhz);
      rst = 1'b0;
      tick(2);

      write_px(0, 24'hFF8001);
      write_px(1, 24'h123456);
      for (int i = 2; i < int'(NUM_LEDS); i++) write_px(ADDR_W'(i), 24'($urandom));
      write_px(ADDR_W'(NUM_LEDS + 1), 24'hABCDEF);   // out of range, dropped

      // Full brightness passes data; latch gap counted from drv_idle
      pix_if.drv_idle = 1'b0;
      start_frame(8'd255);
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin tick(1); n++; end
      check("t1_drained", 32'(exp_q.size()), 0);
      tick(5);
      check("t1_drain_busy", 32'(busy_o), 1);
      check("t1_drain_nodone", 32'(frame_done_o), 0);
      pix_if.drv_idle = 1'b1;
      wait_done("t1", 500, cyc);
      // one edge to leave DRAIN, then LATCH_CYCLES of gap
      check("t1_latch_gap", 32'(cyc), 32'(LATCH_CYCLES + 1));
      tick(1);
      check("t1_done_pulse", 32'(frame_done_o), 0);
      check("t1_idle", 32'(busy_o), 0);

      // Half and zero brightness
      write_px(0, 24'hFF8040);
      brightness_i = 8'd127;
      exp_q.push_back(24'h7F4020);
      for (int i = 1; i < int'(NUM_LEDS); i++) exp_q.push_back(scale(shadow[i], 8'd127));
      pulse_start();
      wait_done("t2a", 500, cyc);
      tick(1);
      brightness_i = 8'd0;
      for (int i = 0; i < int'(NUM_LEDS); i++) exp_q.push_back(24'h000000);
      pulse_start();
      wait_done("t2b", 500, cyc);
      tick(1);

      // Back-pressure: hold ready low in SEND
      pix_if.pixel_ready = 1'b0;
      start_frame(8'd200);
      n = 0;
      while (pix_if.pixel_valid !== 1'b1 && n < 10) begin tick(1); n++; end
      check("t3_valid_up", 32'(pix_if.pixel_valid), 1);
      held = pix_if.pixel_grb;
      brightness_i = 8'd7;            // mid-frame change must not apply
      write_px(0, 24'h00FF00);        // pixel 0 already fetched: next frame
      for (int i = 0; i < 9; i++) begin
         check("t3_hold_valid", 32'(pix_if.pixel_valid), 1);
         check("t3_hold_grb", 32'(pix_if.pixel_grb), 32'(held));
         tick(1);
      end
      pix_if.pixel_ready = 1'b1;
      wait_done("t3", 500, cyc);
      tick(1);
      start_frame(8'd90);
      wait_done("t3b", 500, cyc);
      tick(1);

      // Three requests while busy collapse into one chained frame
      start_frame(8'd255);
      tick(3);
      for (int i = 0; i < 3; i++) begin pulse_start(); tick(2); end
      push_frame(8'd255);
      wait_done("t4a", 500, cyc);
      tick(1);
      check("t4_no_idle", 32'(busy_o), 1);
      check("t4_idx0", 32'(cur_index_o), 0);
      check("t4_done_pulse", 32'(frame_done_o), 0);
      wait_done("t4b", 500, cyc);
      tick(20);
      check("t4_single_extra", 32'(busy_o), 0);
      check("t4_queue", 32'(exp_q.size()), 0);

      // Auto refresh: a frame every REFRESH_CYCLES
      brightness_i = 8'd255;
      for (int i = 0; i < 3; i++) push_frame(8'd255);
      auto_refresh_i = 1'b1;
      wait_done("t5a", 400, cyc);
      for (int k = 0; k < 2; k++) begin
         tick(1);
         wait_done("t5b", 400, cyc);
         check("t5_period", 32'(cyc + 1), 32'(REFRESH_CYCLES));
      end
      auto_refresh_i = 1'b0;
      tick(40);
      check("t5_stopped", 32'(busy_o), 0);
      check("t5_queue", 32'(exp_q.size()), 0);

      // Reset while pixel 5 is waiting in SEND
      start_frame(8'd255);
      n = 0;
      while (cur_index_o != ADDR_W'(5) && n < 60) begin tick(1); n++; end
      pix_if.pixel_ready = 1'b0;
      n = 0;
      while (pix_if.pixel_valid !== 1'b1 && n < 5) begin tick(1); n++; end
      check("t6_at_px5", 32'(cur_index_o), 5);
      check("t6_queue_left", 32'(exp_q.size()), 3);
      @(negedge clk_50Mhz);
      #2 rst = 1'b1;
      #1;
      check("t6_valid", 32'(pix_if.pixel_valid), 0);
      check("t6_grb", 32'(pix_if.pixel_grb), 0);
      check("t6_busy", 32'(busy_o), 0);
      check("t6_idx", 32'(cur_index_o), 0);
      check("t6_done", 32'(frame_done_o), 0);
      exp_q.delete();
      @(negedge clk_50Mhz);
      rst = 1'b0;
      pix_if.pixel_ready = 1'b1;
      tick(1);
      start_frame(8'd255);
      wait_done("t6", 500, cyc);
      tick(3);
      check("t6_queue", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
Frame-level controller for the WS2812 LED chain. It holds a pixel buffer of NUM_LEDS 24-bit GRB words written by the host. On a frame request it scales each pixel by a global brightness and hands the pixels one at a time to the bit-level LED driver through a valid/ready handshake. It then enforces the WS2812 latch gap and reports frame completion.

Parameters:
NUM_LEDS, 64, number of pixels per frame (at least 2)
ADDR_W, 6, pixel address width; 2^ADDR_W >= NUM_LEDS
LATCH_CYCLES, 2600, clk_50Mhz cycles of line-low latch gap (>= 50 us)
REFRESH_CYCLES, 833333, auto-refresh period in cycles (60 Hz)
REFRESH_W, 20, refresh counter width

Ports:
clk_50Mhz  in  1  system clock, 50 MHz
rst  in  1  asynchronous active-high reset
wr_en  in  1  pixel buffer write strobe
wr_addr  in  ADDR_W  pixel write address; writes with wr_addr >= NUM_LEDS are ignored
wr_grb  in  24  pixel write data, G[23:16] R[15:8] B[7:0]
frame_start  in  1  one-cycle frame request
auto_refresh  in  1  enables the periodic frame request timer
brightness  in  8  global brightness
pixel_grb  out  24  scaled pixel to driver
pixel_valid  out  1  pixel_grb is valid
pixel_ready  in  1  driver can accept a pixel
drv_idle  in  1  driver has finished shifting all bits
busy  out  1  frame in progress (any state other than IDLE)
frame_done  out  1  one-cycle pulse at end of latch gap
cur_index  out  ADDR_W  index of the pixel being fetched or sent

Behaviour:
- Reset (async, rst=1): state IDLE; pixel_grb=0, pixel_valid=0, busy=0, frame_done=0, cur_index=0; pending flag, refresh counter, latch counter and latched brightness cleared. Pixel buffer contents are not cleared.
- Reset mid-frame aborts immediately with no latch gap. The driver shares rst.
- Buffer: single write port and synchronous read port with 1-cycle latency.
  - A write and a read to the same address in the same cycle return the old data.
  - A write to a pixel already sent takes effect in the next frame.
- Frame request = frame_start, or refresh timer expiry.
  - In IDLE, a request starts the frame on the next cycle.
  - While busy, requests set a single pending flag; multiple requests collapse into one.
  - On DONE, a set pending flag starts a new frame directly and the flag clears.
- Refresh timer:
  - auto_refresh=0 holds the counter at 0.
  - Otherwise the counter increments each cycle; at REFRESH_CYCLES-1 it wraps to 0 and raises a request.
- State machine:
  - IDLE: on request, latch brightness into bscale = brightness+1 (9 bits), set cur_index=0, go to FETCH.
  - FETCH: issue buffer read at cur_index, go to SCALE.
  - SCALE: for each 8-bit channel c, out = (c*bscale)>>8 (17-bit product, keep bits [15:8]); register into pixel_grb; pixel_valid=1; go to SEND.
    - brightness=255 passes data unchanged; brightness=0 outputs 0.
  - SEND: hold pixel_valid and pixel_grb stable until pixel_valid && pixel_ready.
    - On the accepting cycle, drop pixel_valid at the next edge.
    - If cur_index == NUM_LEDS-1, go to DRAIN; else increment cur_index and go to FETCH.
  - DRAIN: wait for drv_idle=1, then clear the latch counter and go to LATCH.
  - LATCH: count to LATCH_CYCLES-1, then go to DONE.
  - DONE: frame_done=1 for exactly one cycle; go to IDLE or, if pending, to FETCH with a new brightness latch.
- Minimum per-pixel overhead: 3 cycles (FETCH, SCALE, SEND) when pixel_ready is already high.
- brightness changes mid-frame have no effect until the next frame.
- pixel_ready high outside SEND is ignored.
- cur_index never exceeds NUM_LEDS-1.

Test Plan:
1. Write pixel 0=0xFF8001, pixel 1=0x123456, brightness=255, pixel_ready held 1, frame_start -> pixel_grb sequence 0xFF8001, 0x123456, ... with pixel_valid high exactly 1 cycle each; frame_done after drv_idle plus 2600 cycles.
2. brightness=127, pixel 0x FF8040 -> pixel_grb=0x7F4020; brightness=0 -> 0x000000.
3. pixel_ready held 0 for 10 cycles in SEND -> pixel_valid and pixel_grb stable for all 10 cycles; exactly one transfer when ready rises.
4. Three frame_start pulses while busy -> exactly one extra frame, starting the cycle after frame_done with no IDLE cycle in between.
5. auto_refresh=1 with REFRESH_CYCLES=100 (test override) -> frames start every 100 cycles when a frame fits; otherwise back-to-back via the pending flag.
6. rst asserted while sending pixel 5 -> all outputs 0 asynchronously; busy=0; next frame_start begins at index 0; buffer data retained.
